// File: rtl/fd_controller.sv
// fd_controller: FAST corner-detection frame scanner that fetches each candidate's center and 16-pixel circle, then hands the results to a datapath and a downstream consumer
module fd_controller #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    thresIn,
  output logic          memRe,
  output logic [AW-1:0] memAddr,
  input  logic [7:0]    memData,
  output logic [7:0]    refPixel,
  output logic [127:0]  adjPixel,
  output logic [7:0]    thres,
  input  logic          isCorner,
  input  logic [31:0]   compare,
  output logic          cornerValid,
  input  logic          cornerReady,
  output logic [11:0]   cornerX,
  output logic [11:0]   cornerY,
  output logic [31:0]   cornerCmp,
  output logic          busy,
  output logic          done,
  output logic [15:0]   cornerCount
);
  typedef enum logic [2:0] {IDLE, FETCH, EVAL, OUT, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [11:0] x, y;
  logic [AW-1:0] row;
  logic signed [2:0] dx, dy;
  logic [6:0] adj_lo;
  logic last_x, last_y, adv;
  // circle offset for read k; k=0 is the center
  always_comb begin
    {dx, dy} = {3'sd0, 3'sd0};
    case (cnt)
      5'd1:  {dx, dy} = {3'sd0, -3'sd3};
      5'd2:  {dx, dy} = {3'sd1, -3'sd3};
      5'd3:  {dx, dy} = {3'sd2, -3'sd2};
      5'd4:  {dx, dy} = {3'sd3, -3'sd1};
      5'd5:  {dx, dy} = {3'sd3, 3'sd0};
      5'd6:  {dx, dy} = {3'sd3, 3'sd1};
      5'd7:  {dx, dy} = {3'sd2, 3'sd2};
      5'd8:  {dx, dy} = {3'sd1, 3'sd3};
      5'd9:  {dx, dy} = {3'sd0, 3'sd3};
      5'd10: {dx, dy} = {-3'sd1, 3'sd3};
      5'd11: {dx, dy} = {-3'sd2, 3'sd2};
      5'd12: {dx, dy} = {-3'sd3, 3'sd1};
      5'd13: {dx, dy} = {-3'sd3, 3'sd0};
      5'd14: {dx, dy} = {-3'sd3, -3'sd1};
      5'd15: {dx, dy} = {-3'sd2, -3'sd2};
      5'd16: {dx, dy} = {-3'sd1, -3'sd3};
      default: {dx, dy} = {3'sd0, 3'sd0};
    endcase
  end
  assign memRe = state == FETCH && cnt <= 5'd16;
  assign memAddr = row + AW'(x) + {{(AW-3){dy[2]}}, dy} * AW'(IMG_W) + {{(AW-3){dx[2]}}, dx};
  assign adj_lo = {2'b00, 5'd17 - cnt} << 3;
  assign last_x = x == 12'(IMG_W - 4);
  assign last_y = y == 12'(IMG_H - 4);
  assign adv = (state == EVAL && !isCorner) || (state == OUT && cornerReady);
  // scan sequencing, operand capture, result handshake and position advance
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      row <= '0;
      refPixel <= '0;
      adjPixel <= '0;
      thres <= '0;
      cornerValid <= 1'b0;
      cornerX <= '0;
      cornerY <= '0;
      cornerCmp <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cornerCount <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          thres <= thresIn;
          cornerCount <= '0;
          x <= 12'd3;
          y <= 12'd3;
          row <= AW'(3 * IMG_W);
          cnt <= '0;
          busy <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd1) refPixel <= memData;
          if (cnt >= 5'd2) adjPixel[adj_lo +: 8] <= memData;
          if (cnt == 5'd17) state <= EVAL;
        end
        EVAL: if (isCorner) begin
          cornerCmp <= compare;
          cornerX <= x;
          cornerY <= y;
          cornerValid <= 1'b1;
          state <= OUT;
        end
        OUT: if (cornerReady) begin
          cornerValid <= 1'b0;
          cornerCount <= &cornerCount ? cornerCount : cornerCount + 16'd1;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (adv) begin
        cnt <= '0;
        x <= last_x ? 12'd3 : x + 12'd1;
        y <= last_x ? y + 12'd1 : y;
        row <= last_x ? row + AW'(IMG_W) : row;
        state <= last_x && last_y ? DONE : FETCH;
        busy <= !(last_x && last_y);
        done <= last_x && last_y;
      end
    end
  end
endmodule

// File: tb/tb_fd_controller.sv
// tb_fd_controller: scoreboard bench for the corner-detection scanner on a 16x16 image
module tb_fd_controller;
  localparam int W = 16;
  localparam int H = 16;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic reset, start, memRe, isCorner, cornerValid, cornerReady, busy, done;
  logic [7:0] thresIn, memData, refPixel, thres;
  logic [AW-1:0] memAddr;
  logic [127:0] adjPixel;
  logic [31:0] compare, cornerCmp;
  logic [11:0] cornerX, cornerY;
  logic [15:0] cornerCount;
  int errors = 0;
  int checks = 0;
  logic [7:0] mem [256];
  int cdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int cdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
  typedef struct {int x; int y; logic [31:0] cmp;} corner_t;
  int addr_q[$];
  corner_t exp_q[$];

  fd_controller #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .thresIn(thresIn),
    .memRe(memRe), .memAddr(memAddr), .memData(memData),
    .refPixel(refPixel), .adjPixel(adjPixel), .thres(thres),
    .isCorner(isCorner), .compare(compare),
    .cornerValid(cornerValid), .cornerReady(cornerReady),
    .cornerX(cornerX), .cornerY(cornerY), .cornerCmp(cornerCmp),
    .busy(busy), .done(done), .cornerCount(cornerCount)
  );

  always #5 clk = ~clk;

  // one-cycle-latency pixel memory
  always_ff @(posedge clk) if (memRe) memData <= mem[memAddr[7:0]];

  // datapath stub: circle pixel darker than ref by more than thres -> 2'b01, corner when 9 or more
  always_comb begin
    compare = '0;
    for (int i = 1; i <= 16; i++)
      if (int'(refPixel) - int'(adjPixel[8*(16-i) +: 8]) > int'(thres)) compare[33-2*i -: 2] = 2'b01;
    isCorner = $countones(compare) >= 9;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] model_cmp(input int x, input int y, input int thr);
    logic [31:0] c = '0;
    for (int k = 0; k < 16; k++)
      if (int'(mem[y*W+x]) - int'(mem[(y+cdy[k])*W + x + cdx[k]]) > thr) c[31-2*k -: 2] = 2'b01;
    return c;
  endfunction

  task automatic build_expect(input int thr);
    corner_t e;
    addr_q.delete();
    exp_q.delete();
    for (int y = 3; y <= H-4; y++)
      for (int x = 3; x <= W-4; x++) begin
        addr_q.push_back(y*W + x);
        for (int k = 0; k < 16; k++) addr_q.push_back((y+cdy[k])*W + x + cdx[k]);
        e.x = x;
        e.y = y;
        e.cmp = model_cmp(x, y, thr);
        if ($countones(e.cmp) >= 9) exp_q.push_back(e);
      end
  endtask

  task automatic load_flat(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic load_corner();
    for (int i = 0; i < 256; i++) mem[i] = 8'd200;
    for (int k = 0; k < 9; k++) mem[(8+cdy[k])*W + 8 + cdx[k]] = 8'd50;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] t);
    thresIn = t;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    thresIn = 8'd0;
    cornerReady = 1'b0;
    repeat (3) step();
    checks++; if ({memRe, cornerValid, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {memRe, cornerValid, busy, done}); end
    checks++; if (cornerCount !== 16'd0 || thres !== 8'd0 || refPixel !== 8'd0) begin errors++; $display("FAIL reset_regs got cnt=%0d thres=%0d ref=%0d exp 0", cornerCount, thres, refPixel); end
    checks++; if (adjPixel !== 128'd0 || cornerCmp !== 32'd0 || cornerX !== 12'd0 || cornerY !== 12'd0) begin errors++; $display("FAIL reset_payload got adj=%h cmp=%h x=%0d y=%0d exp 0", adjPixel, cornerCmp, cornerX, cornerY); end
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || memRe !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b memRe=%b exp 0 0", busy, memRe); end
  endtask

  task automatic test_flat();
    int n = 0;
    int nrd = 0;
    int a;
    int first [4];
    logic seen_valid = 1'b0;
    load_flat(8'd100);
    build_expect(10);
    cornerReady = 1'b1;
    do_start(8'd10);
    while (!done && n < 3000) begin
      if (memRe) begin
        a = addr_q.size() != 0 ? addr_q.pop_front() : -1;
        if (nrd < 4) first[nrd] = int'(memAddr);
        nrd++;
        checks++; if (int'(memAddr) !== a) begin errors++; $display("FAIL flat_addr cycle %0d got %0d exp %0d", n, memAddr, a); end
      end
      if (cornerValid) seen_valid = 1'b1;
      step();
      n++;
    end
    checks++; if (n !== 1900) begin errors++; $display("FAIL flat_cycles got %0d exp 1900", n); end
    checks++; if (first[0] !== 51 || first[1] !== 3 || first[2] !== 4 || first[3] !== 21) begin errors++; $display("FAIL flat_first_addrs got %0d %0d %0d %0d exp 51 3 4 21", first[0], first[1], first[2], first[3]); end
    checks++; if (nrd !== 1700 || addr_q.size() !== 0) begin errors++; $display("FAIL flat_reads got %0d left %0d exp 1700 0", nrd, addr_q.size()); end
    checks++; if (seen_valid !== 1'b0 || cornerCount !== 16'd0) begin errors++; $display("FAIL flat_no_corner got valid=%b count=%0d exp 0 0", seen_valid, cornerCount); end
    checks++; if (busy !== 1'b0 || thres !== 8'd10) begin errors++; $display("FAIL flat_done_state got busy=%b thres=%0d exp 0 10", busy, thres); end
    step();
    checks++; if (done !== 1'b0 || cornerCount !== 16'd0) begin errors++; $display("FAIL flat_done_pulse got done=%b count=%0d exp 0 0", done, cornerCount); end
  endtask

  task automatic test_corner();
    int n = 0;
    int xfers = 0;
    corner_t e;
    load_corner();
    build_expect(20);
    checks++; if (exp_q.size() !== 1) begin errors++; $display("FAIL corner_model got %0d corners exp 1", exp_q.size()); end
    cornerReady = 1'b1;
    do_start(8'd20);
    while (!done && n < 3000) begin
      if (cornerValid && cornerReady) begin
        xfers++;
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL corner_extra got (%0d,%0d) exp none", cornerX, cornerY);
        end else begin
          e = exp_q.pop_front();
          checks++; if (int'(cornerX) !== e.x || int'(cornerY) !== e.y) begin errors++; $display("FAIL corner_xy got (%0d,%0d) exp (%0d,%0d)", cornerX, cornerY, e.x, e.y); end
          checks++; if (cornerCmp !== e.cmp) begin errors++; $display("FAIL corner_cmp got %h exp %h", cornerCmp, e.cmp); end
          checks++; if (cornerCmp[31:14] !== 18'h15555) begin errors++; $display("FAIL corner_cmp_hi got %h exp 15555", cornerCmp[31:14]); end
        end
      end
      step();
      n++;
    end
    checks++; if (xfers !== 1 || exp_q.size() !== 0) begin errors++; $display("FAIL corner_xfers got %0d left %0d exp 1 0", xfers, exp_q.size()); end
    checks++; if (cornerCount !== 16'd1) begin errors++; $display("FAIL corner_count got %0d exp 1", cornerCount); end
    checks++; if (n !== 1901) begin errors++; $display("FAIL corner_cycles got %0d exp 1901", n); end
    step();
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [55:0] pay;
    load_corner();
    cornerReady = 1'b0;
    do_start(8'd20);
    while (!cornerValid && n < 3000) begin
      step();
      n++;
    end
    checks++; if (cornerValid !== 1'b1 || cornerX !== 12'd8 || cornerY !== 12'd8) begin errors++; $display("FAIL bp_arrive got valid=%b (%0d,%0d) exp 1 (8,8)", cornerValid, cornerX, cornerY); end
    pay = {cornerX, cornerY, cornerCmp};
    for (int i = 0; i < 6; i++) begin
      checks++; if (cornerValid !== 1'b1 || memRe !== 1'b0 || {cornerX, cornerY, cornerCmp} !== pay) begin errors++; $display("FAIL bp_hold cycle %0d got valid=%b memRe=%b pay=%h exp 1 0 %h", i, cornerValid, memRe, {cornerX, cornerY, cornerCmp}, pay); end
      if (i == 5) cornerReady = 1'b1;
      step();
    end
    checks++; if (cornerValid !== 1'b0 || memRe !== 1'b1 || memAddr !== 9'd137) begin errors++; $display("FAIL bp_resume got valid=%b memRe=%b addr=%0d exp 0 1 137", cornerValid, memRe, memAddr); end
    checks++; if (cornerCount !== 16'd1) begin errors++; $display("FAIL bp_count got %0d exp 1", cornerCount); end
    n = 0;
    while (!done && n < 3000) begin
      step();
      n++;
    end
    checks++; if (done !== 1'b1 || cornerCount !== 16'd1) begin errors++; $display("FAIL bp_finish got done=%b count=%0d exp 1 1", done, cornerCount); end
    step();
  endtask

  task automatic test_start_ignored();
    int n = 0;
    load_corner();
    cornerReady = 1'b1;
    do_start(8'd20);
    repeat (30) begin
      step();
      n++;
    end
    thresIn = 8'd99;
    start = 1'b1;
    step();
    n++;
    start = 1'b0;
    checks++; if (thres !== 8'd20 || busy !== 1'b1) begin errors++; $display("FAIL ign_thres got thres=%0d busy=%b exp 20 1", thres, busy); end
    while (!done && n < 3000) begin
      step();
      n++;
    end
    checks++; if (n !== 1901 || cornerCount !== 16'd1) begin errors++; $display("FAIL ign_frame got cycles=%0d count=%0d exp 1901 1", n, cornerCount); end
    step();
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    load_flat(8'd100);
    cornerReady = 1'b1;
    do_start(8'd10);
    repeat (500) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({busy, memRe, done} !== 3'b0 || thres !== 8'd0 || refPixel !== 8'd0 || adjPixel !== 128'd0) begin errors++; $display("FAIL mid_reset got busy/memRe/done=%b thres=%0d ref=%0d exp 000 0 0", {busy, memRe, done}, thres, refPixel); end
    repeat (40) begin
      step();
      if (done || busy) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL mid_no_done got activity=%b exp 0", saw); end
    do_start(8'd10);
    checks++; if (memRe !== 1'b1 || memAddr !== 9'd51 || busy !== 1'b1) begin errors++; $display("FAIL mid_restart got memRe=%b addr=%0d busy=%b exp 1 51 1", memRe, memAddr, busy); end
    checks++; if (cornerCount !== 16'd0 || thres !== 8'd10) begin errors++; $display("FAIL mid_restart_regs got count=%0d thres=%0d exp 0 10", cornerCount, thres); end
  endtask

  task automatic test_reset_out();
    int n = 0;
    logic saw = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_corner();
    cornerReady = 1'b0;
    do_start(8'd20);
    while (!cornerValid && n < 3000) begin
      step();
      n++;
    end
    checks++; if (cornerValid !== 1'b1) begin errors++; $display("FAIL out_arrive got valid=%b exp 1", cornerValid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (cornerValid !== 1'b0 || busy !== 1'b0 || cornerX !== 12'd0 || cornerCmp !== 32'd0) begin errors++; $display("FAIL out_reset got valid=%b busy=%b x=%0d cmp=%h exp 0 0 0 0", cornerValid, busy, cornerX, cornerCmp); end
    repeat (20) begin
      step();
      if (done || cornerValid) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL out_quiet got activity=%b exp 0", saw); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_corner();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_reset_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
